uart_fifo_periph: RTL and testbench

//  Memory-mapped UART peripheral with independent RX and TX FIFOs, runtime baud divisor,

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_sync_fifo.sv | 45 ++++
 rtl/uart_fifo_periph.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_fifo_periph.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO UART: register map, STATUS/CTRL bit positions,
// FSM state encodings and the reset baud-divisor calculation.
package uart_pkg;

  localparam logic [3:0] ADDR_STATUS = 4'h0;
  localparam logic [3:0] ADDR_RXDATA = 4'h1;
  localparam logic [3:0] ADDR_CTRL   = 4'h2;
  localparam logic [3:0] ADDR_TXDATA = 4'h3;
  localparam logic [3:0] ADDR_ERRCLR = 4'h4;
  localparam logic [3:0] ADDR_DIV_LO = 4'h5;
  localparam logic [3:0] ADDR_DIV_HI = 4'h6;

  localparam int ST_RX_NEMPTY   = 0;
  localparam int ST_TX_NFULL    = 1;
  localparam int ST_TX_IDLE     = 2;
  localparam int ST_RX_OVERRUN  = 3;
  localparam int ST_FRAME_ERR   = 4;
  localparam int ST_PARITY_ERR  = 5;
  localparam int ST_TX_OVERFLOW = 6;

  localparam int CTRL_RX_EN      = 0;
  localparam int CTRL_TX_EN      = 1;
  localparam int CTRL_IRQ_RX_EN  = 2;
  localparam int CTRL_IRQ_TXE_EN = 3;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  // Divisor for 16x oversampling, clamped into the 16-bit counter range.
  function automatic logic [15:0] div_reset(input longint clk_hz, input longint baud);
    longint q;
    q = clk_hz / (baud * 16) - 1;
    if (q < 0) return 16'h0000;
    if (q > 65535) return 16'hFFFF;
    return q[15:0];
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with combinational head output; extra pointer MSB tells full from empty.
// A pop is ignored when empty; a push into a full FIFO is accepted only if a pop frees a slot
// in the same cycle, otherwise the caller sees full and decides what to flag.
module uart_sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(Depth);

  logic [AW:0]      wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  // Pointer update; both pointers may advance in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_periph.sv
// Memory-mapped UART with RX/TX FIFOs, 16x oversampled baud tick, parity, sticky errors, level irq.
// A strobe on a RW register (CTRL, DIV) writes wdata and returns the value held before the write.
// data and irq are registered: a read result appears the cycle after addr_strobe.
module uart_fifo_periph
  import uart_pkg::*;
#(
  parameter int DataBitsSize = 8,
  parameter int ParityMode   = 0,
  parameter int StopBitsSize = 1,
  parameter int RxDepth      = 16,
  parameter int TxDepth      = 16,
  parameter int ClockFreqHz  = 10000000,
  parameter int BaudRate     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_sig,
  output logic       tx_sig,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] data,
  input  logic       addr_strobe,
  output logic       irq
);
  localparam int          DW       = DataBitsSize;
  localparam logic [15:0] DivReset = div_reset(ClockFreqHz, BaudRate);

  logic [3:0]    ctrl_q, ctrl_d, err_q, err_d, err_set, err_clr;
  logic [15:0]   div_q, div_d, cnt_q;
  logic [7:0]    data_q, data_d, rd_val, tx_rdata, rx_rdata;
  logic          irq_q, irq_d, tick16;
  logic          tx_push, tx_pop, tx_full, tx_empty, tx_idle;
  logic          rx_push, rx_pop, rx_full, rx_empty, set_frame, set_parity;
  tx_state_e     tx_state_q, tx_state_d;
  rx_state_e     rx_state_q, rx_state_d;
  logic [3:0]    tx_tick_q, tx_tick_d, rx_tick_q, rx_tick_d;
  logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [DW-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic          tx_par_q, tx_par_d, tx_q, tx_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;

  assign tick16  = (cnt_q == 16'd0);
  assign tx_idle = tx_empty && (tx_state_q == TX_IDLE);
  assign tx_push = addr_strobe && (addr == ADDR_TXDATA);
  assign rx_pop  = addr_strobe && (addr == ADDR_RXDATA) && !rx_empty;
  assign tx_sig  = tx_q;
  assign data    = data_q;
  assign irq     = irq_q;

  uart_sync_fifo #(.Width(8), .Depth(TxDepth)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .wdata(wdata), .pop(tx_pop),
    .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
  );

  uart_sync_fifo #(.Width(8), .Depth(RxDepth)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(8'(rx_shift_q)), .pop(rx_pop),
    .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
  );

  // Register read mux, register writes, sticky error flags (set beats clear) and irq.
  always_comb begin
    rd_val = 8'h00;
    case (addr)
      ADDR_STATUS: rd_val = {1'b0, err_q, tx_idle, ~tx_full, ~rx_empty};
      ADDR_RXDATA: rd_val = rx_empty ? 8'h00 : rx_rdata;
      ADDR_CTRL:   rd_val = {4'h0, ctrl_q};
      ADDR_DIV_LO: rd_val = div_q[7:0];
      ADDR_DIV_HI: rd_val = div_q[15:8];
      default:     rd_val = 8'h00;
    endcase
    data_d = addr_strobe ? rd_val : data_q;
    ctrl_d = (addr_strobe && addr == ADDR_CTRL) ? wdata[3:0] : ctrl_q;
    div_d  = div_q;
    if (addr_strobe && addr == ADDR_DIV_LO) div_d[7:0]  = wdata;
    if (addr_strobe && addr == ADDR_DIV_HI) div_d[15:8] = wdata;
    err_set = {tx_push & tx_full & ~tx_pop, set_parity, set_frame, rx_push & rx_full & ~rx_pop};
    err_clr = (addr_strobe && addr == ADDR_ERRCLR) ? wdata[6:3] : 4'h0;
    err_d   = (err_q & ~err_clr) | err_set;
    irq_d   = (ctrl_q[CTRL_IRQ_RX_EN] & ~rx_empty) | (ctrl_q[CTRL_IRQ_TXE_EN] & tx_empty) | (|err_q);
  end

  // TX framing: start, data LSB first, optional parity, stop bits; each bit lasts 16 ticks.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    if (tx_state_q == TX_IDLE) begin
      if (tick16 && ctrl_q[CTRL_TX_EN] && !tx_empty) begin
        tx_pop     = 1'b1;
        tx_state_d = TX_START;
        tx_tick_d  = 4'd0;
        tx_shift_d = tx_rdata[DW-1:0];
        tx_par_d   = (ParityMode == 1) ? ~^tx_rdata[DW-1:0] : ^tx_rdata[DW-1:0];
      end
    end else if (tick16) begin
      tx_tick_d = tx_tick_q + 4'd1;
      if (tx_tick_q == 4'd15) begin
        case (tx_state_q)
          TX_START: begin
            tx_state_d = TX_DATA;
            tx_bit_d   = 3'd0;
          end
          TX_DATA: begin
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'(DW-1)) begin
              tx_bit_d   = 3'd0;
              tx_state_d = (ParityMode != 0) ? TX_PARITY : TX_STOP;
            end
          end
          TX_PARITY: begin
            tx_state_d = TX_STOP;
            tx_bit_d   = 3'd0;
          end
          default: begin
            tx_bit_d = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'(StopBitsSize-1)) tx_state_d = TX_IDLE;
          end
        endcase
      end
    end
    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_shift_d[0];
      TX_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // RX framing: falling edge starts a frame, each bit sampled mid-bit; byte pushed at mid stop bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    set_frame  = 1'b0;
    set_parity = 1'b0;
    if (rx_state_q == RX_IDLE) begin
      if (ctrl_q[CTRL_RX_EN] && rx_prev_q && !rx_sync_q) begin
        rx_state_d = RX_START;
        rx_tick_d  = 4'd0;
      end
    end else if (tick16) begin
      rx_tick_d = rx_tick_q + 4'd1;
      if (rx_state_q == RX_START) begin
        if (rx_tick_q == 4'd7) begin
          rx_tick_d  = 4'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end else if (rx_tick_q == 4'd15) begin
        case (rx_state_q)
          RX_DATA: begin
            rx_shift_d = {rx_sync_q, rx_shift_q[DW-1:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'(DW-1)) rx_state_d = (ParityMode != 0) ? RX_PARITY : RX_STOP;
          end
          RX_PARITY: begin
            set_parity = rx_sync_q != ((ParityMode == 1) ? ~^rx_shift_q : ^rx_shift_q);
            rx_state_d = RX_STOP;
          end
          default: begin
            set_frame  = ~rx_sync_q;
            rx_push    = 1'b1;
            rx_state_d = RX_IDLE;
          end
        endcase
      end
    end
  end

  // State registers, baud tick down-counter and rx_sig synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= 4'h3;
      div_q      <= DivReset;
      cnt_q      <= DivReset;
      err_q      <= 4'h0;
      data_q     <= 8'h00;
      irq_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      div_q      <= div_d;
      cnt_q      <= tick16 ? div_q : cnt_q - 16'd1;
      err_q      <= err_d;
      data_q     <= data_d;
      irq_q      <= irq_d;
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      rx_meta_q  <= rx_sig;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

endmodule

// File: tb/tb_uart_fifo_periph.sv
// Directed bench for uart_fifo_periph at 16 clk per bit: one 8N1 instance and one 8E1
// instance share the register bus; each has its own serial pins.
module tb_uart_fifo_periph;
  logic       clk = 1'b0, rst = 1'b1, rx_a = 1'b1, rx_b = 1'b1, addr_strobe = 1'b0;
  logic [3:0] addr = 4'h0;
  logic [7:0] wdata = 8'h00;
  logic       tx_a, tx_b, irq_a, irq_b;
  logic [7:0] data_a, data_b;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_fifo_periph #(.ParityMode(0), .ClockFreqHz(1600000), .BaudRate(100000)) dut (
    .clk(clk), .rst(rst), .rx_sig(rx_a), .tx_sig(tx_a), .addr(addr), .wdata(wdata),
    .data(data_a), .addr_strobe(addr_strobe), .irq(irq_a)
  );

  uart_fifo_periph #(.ParityMode(2), .ClockFreqHz(1600000), .BaudRate(100000)) dut_p (
    .clk(clk), .rst(rst), .rx_sig(rx_b), .tx_sig(tx_b), .addr(addr), .wdata(wdata),
    .data(data_b), .addr_strobe(addr_strobe), .irq(irq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One strobed access; on return data holds the result of this access.
  task automatic bus(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; addr_strobe = 1'b1;
    @(posedge clk); #1;
    addr_strobe = 1'b0;
  endtask

  task automatic drive_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else rx_a = v;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic rx_frame(input bit sel, input logic [7:0] b, input bit has_par,
                          input logic par, input logic stop);
    @(posedge clk); #1;
    drive_rx(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_rx(sel, b[i]);
    if (has_par) drive_rx(sel, par);
    drive_rx(sel, stop);
    if (sel) rx_b = 1'b1;
    else rx_a = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Waits for a start bit on tx_a and checks all 160 cycles of an 8N1 frame.
  task automatic expect_tx(input string tag, input logic [7:0] b);
    logic [9:0] exp_bits;
    logic [7:0] got;
    int errs;
    bit found;
    exp_bits = {1'b1, b, 1'b0};
    got = 8'h00;
    errs = 0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #1;
      if (tx_a === 1'b0) found = 1'b1;
    end
    chk({tag, "_start"}, 32'(found), 32'd1);
    if (found) begin
      for (int k = 1; k < 160; k++) begin
        @(posedge clk); #1;
        if (tx_a !== exp_bits[k/16]) errs++;
        if ((k % 16 == 8) && (k / 16 >= 1) && (k / 16 <= 8)) got[k/16-1] = tx_a;
      end
      chk({tag, "_byte"}, 32'(got), 32'(b));
      chk({tag, "_badcycles"}, 32'(errs), 32'd0);
    end
  endtask

  initial begin
    int lows;
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_data", 32'(data_a), 32'h00);
    chk("rst_irq", 32'(irq_a), 32'd0);
    rst = 1'b0;
    bus(4'h0, 8'h00);
    chk("rst_status", 32'(data_a), 32'h06);
    bus(4'h2, 8'h03);
    chk("rst_ctrl", 32'(data_a), 32'h03);
    bus(4'h6, 8'h00);
    chk("rst_div_hi", 32'(data_a), 32'h00);

    // 1: single TX frame
    bus(4'h3, 8'h55);
    expect_tx("tx1", 8'h55);
    repeat (5) @(posedge clk);
    bus(4'h0, 8'h00);
    chk("tx1_status_idle", 32'(data_a), 32'h06);
    chk("tx1_irq", 32'(irq_a), 32'd0);

    // 2: single RX frame, read twice
    rx_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    bus(4'h0, 8'h00);
    chk("rx2_status", 32'(data_a), 32'h07);
    bus(4'h1, 8'h00);
    chk("rx2_data", 32'(data_a), 32'hA5);
    bus(4'h1, 8'h00);
    chk("rx2_empty_read", 32'(data_a), 32'h00);
    bus(4'h0, 8'h00);
    chk("rx2_status_after", 32'(data_a), 32'h06);

    // 3: RX overrun
    for (int i = 0; i < 17; i++) rx_frame(1'b0, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
    bus(4'h0, 8'h00);
    chk("rx3_status_overrun", 32'(data_a), 32'h0F);
    chk("rx3_irq", 32'(irq_a), 32'd1);
    bus(4'h4, 8'h08);
    bus(4'h0, 8'h00);
    chk("rx3_status_cleared", 32'(data_a), 32'h07);
    chk("rx3_irq_cleared", 32'(irq_a), 32'd0);
    for (int i = 0; i < 16; i++) begin
      bus(4'h1, 8'h00);
      chk($sformatf("rx3_byte%0d", i), 32'(data_a), 32'h10 + i);
    end
    bus(4'h0, 8'h00);
    chk("rx3_status_drained", 32'(data_a), 32'h06);

    // 4: TX overflow with tx_en=0, then drain
    bus(4'h2, 8'h01);
    chk("tx4_ctrl_old", 32'(data_a), 32'h03);
    for (int i = 0; i < 17; i++) bus(4'h3, 8'h30 + 8'(i));
    bus(4'h0, 8'h00);
    chk("tx4_status_overflow", 32'(data_a), 32'h40);
    chk("tx4_irq", 32'(irq_a), 32'd1);
    bus(4'h2, 8'h03);
    for (int i = 0; i < 16; i++) expect_tx($sformatf("tx4_f%0d", i), 8'h30 + 8'(i));
    lows = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (tx_a === 1'b0) lows++;
    end
    chk("tx4_no_extra_frame", 32'(lows), 32'd0);
    bus(4'h0, 8'h00);
    chk("tx4_status_done", 32'(data_a), 32'h46);
    bus(4'h4, 8'h40);
    bus(4'h0, 8'h00);
    chk("tx4_status_cleared", 32'(data_a), 32'h06);

    // 5: parity and framing errors on the 8E1 instance
    rx_frame(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
    bus(4'h0, 8'h00);
    chk("p5_status_parity", 32'(data_b), 32'h27);
    rx_frame(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    bus(4'h0, 8'h00);
    chk("p5_status_frame", 32'(data_b), 32'h37);
    chk("p5_irq", 32'(irq_b), 32'd1);
    bus(4'h1, 8'h00);
    chk("p5_byte0", 32'(data_b), 32'h01);
    bus(4'h1, 8'h00);
    chk("p5_byte1", 32'(data_b), 32'h3C);

    // 6: glitch rejection, then reset mid-TX
    @(posedge clk); #1;
    rx_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_a = 1'b1;
    repeat (40) @(posedge clk);
    bus(4'h0, 8'h00);
    chk("g6_status_nopush", 32'(data_a), 32'h06);
    bus(4'h3, 8'hF0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      if (tx_a === 1'b0) seen = 1'b1;
    end
    chk("r6_tx_started", 32'(seen), 32'd1);
    repeat (20) @(posedge clk);
    bus(4'h5, 8'h07);
    chk("r6_div_lo_old", 32'(data_a), 32'h00);
    bus(4'h2, 8'h03);
    chk("r6_ctrl", 32'(data_a), 32'h03);
    chk("r6_tx_low_before_rst", 32'(tx_a), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("r6_tx_after_rst", 32'(tx_a), 32'd1);
    chk("r6_data_after_rst", 32'(data_a), 32'h00);
    chk("r6_irq_after_rst", 32'(irq_a), 32'd0);
    rst = 1'b0;
    bus(4'h0, 8'h00);
    chk("r6_status", 32'(data_a), 32'h06);
    bus(4'h5, 8'h00);
    chk("r6_div_lo_reset", 32'(data_a), 32'h00);
    bus(4'h3, 8'h5A);
    expect_tx("r6_tx", 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
